alu_sequential: RTL and testbench
=================================

# alu_sequential

Sequential 32-bit ALU that consumes the 4-bit ALUOperation code produced by the ALU control unit, plus the two register/immediate operands and the shift amount from the decode stage. Logic, arithmetic and compare operations complete in one cycle. Shifts run iteratively, one bit position per clock, to keep the barrel shifter out of the critical path. A Start/Busy/Done handshake lets the datapath stall while a shift is in progress.

## Interface
- N_BITS, 32, operand and result width
- SHAMT_WIDTH, 5, shift-amount width (log2 N_BITS)

- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- Start  input  1  request; sampled only when not Busy
- ALUOperation  input  4  operation code (see Operation)
- A  input  N_BITS  operand rs
- B  input  N_BITS  operand rt / sign-extended immediate
- Shamt  input  SHAMT_WIDTH  shift amount for SLL/SRL
- Busy  output  1  high while an iterative shift is in progress
- Done  output  1  one-cycle pulse: result valid
- ALUResult  output  N_BITS  registered result, held until the next accepted op
- Zero  output  1  registered (ALUResult == 0)
- BranchTaken  output  1  registered branch condition
- IllegalOp  output  1  registered; high when the accepted code is unsupported

## Operation
- Codes and results:
  - 0000 ADD, 1011 LW, 1100 SW: A+B
  - 0111 SUB: A−B
  - 0001 AND: A&B
  - 0100 OR: A|B
  - 0011 NOR: ~(A|B)
  - 1010 LUI: {B[15:0],16'h0}
  - 1000 BEQ: A−B, BranchTaken=(A==B)
  - 1001 BNE: A−B, BranchTaken=(A!=B)
  - 0101 SLL: B<<Shamt, logical
  - 0110 SRL: B>>Shamt, logical, zero fill
- Illegal codes 0010, 1101, 1110, 1111: ALUResult=0, IllegalOp=1, Done pulses normally.
- Arithmetic wraps modulo 2^N_BITS. No overflow flag, no exception.
- BranchTaken=0 for all non-branch codes.
- FSM states:
  - IDLE: Start=1 with a non-shift op, or a shift with Shamt=0, registers the result and pulses Done; FSM stays in IDLE. Start=1 with a shift and Shamt=n>0 loads B into the shift register and n into the counter, then goes to SHIFT.
  - SHIFT: each edge shifts one bit in the latched direction and decrements the counter. The edge on which the counter reaches 0 returns the FSM to IDLE and pulses Done.
- Operation code and direction are latched at acceptance. Input changes while Busy have no effect.
- Start while Busy is ignored, not queued.

## Timing
- Reset (asynchronous, low): state IDLE; ALUResult=0, Zero=1, BranchTaken=0, IllegalOp=0, Busy=0, Done=0, counter=0. Reset mid-shift aborts the shift, and no Done is produced.
- Single-cycle op accepted at edge E0: all outputs update at E0; Done=1 for the cycle E0→E1.
- Shift with Shamt=n>0 accepted at E0: Busy=1 from E0 to En. The final value and Done=1 appear at En. Latency is n cycles; worst case is 31.
- Intermediate shift values may be visible on ALUResult while Busy. Zero, BranchTaken and IllegalOp are valid only when Done=1 or afterwards.
- Back-to-back: Start on the cycle Done is high is accepted, because Busy is already 0. Sustained throughput is one non-shift op per cycle.
- Outputs other than Done hold their values between operations.

## Test plan
- Reset, then ADD A=0xFFFF_FFFF, B=1 -> one cycle later ALUResult=0, Zero=1, Done pulses once, Busy never asserts.
- BEQ A=B=0x1234 -> BranchTaken=1, Zero=1. BNE with the same operands -> BranchTaken=0. BNE A=5, B=3 -> ALUResult=2, BranchTaken=1.
- SLL B=0x0000_0001, Shamt=31 -> Busy high 31 cycles, Done at E31, ALUResult=0x8000_0000. SRL B=0x8000_0000, Shamt=4 -> 0x0800_0000 at E4.
- Shamt=0 SLL B=0xA5A5_A5A5 -> ALUResult=0xA5A5_A5A5 in one cycle, Busy stays 0. LUI B=0x0000_BEEF -> 0xBEEF_0000.
- Start pulsed with OR during a 10-cycle shift -> ignored, only one Done. Start=OR on the Done cycle -> accepted, second Done the next cycle.
- Assert reset at cycle 5 of a 20-bit shift -> outputs return to reset values immediately, no Done. Code 1111 -> ALUResult=0, IllegalOp=1, Done pulse.

Source files
------------

// File: rtl/alu_sequential.sv
// Sequential 32-bit ALU: logic/arithmetic/compare ops finish in one cycle.
// Shifts step one bit position per clock under a Start/Busy/Done handshake.
module alu_sequential #(
  parameter int N_BITS      = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Start,
  input  logic [3:0]             ALUOperation,
  input  logic [N_BITS-1:0]      A,
  input  logic [N_BITS-1:0]      B,
  input  logic [SHAMT_WIDTH-1:0] Shamt,
  output logic                   Busy,
  output logic                   Done,
  output logic [N_BITS-1:0]      ALUResult,
  output logic                   Zero,
  output logic                   BranchTaken,
  output logic                   IllegalOp,
  output logic                   fsm_state
);

  // Handshake: an op is accepted on a rising edge where Start=1 and Busy=0.
  // Done is a one-cycle pulse marking ALUResult/Zero/BranchTaken/IllegalOp valid.
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SUB = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_BNE = 4'b1001;
  localparam logic [3:0] OP_LUI = 4'b1010;
  localparam logic [3:0] OP_LW  = 4'b1011;
  localparam logic [3:0] OP_SW  = 4'b1100;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                 state, state_next;
  logic [SHAMT_WIDTH-1:0] cnt;
  logic                   dir_right;
  logic [N_BITS-1:0]      comb_result;
  logic                   comb_branch;
  logic                   comb_illegal;
  logic                   is_shift;
  logic                   start_shift;
  logic                   last_step;
  logic [N_BITS-1:0]      shift_val;

  assign Busy      = (state == SHIFT);
  assign fsm_state = state;

  // Shift ops resolve to B here: this path is only taken when Shamt is zero.
  always_comb begin
    comb_result  = '0;
    comb_branch  = 1'b0;
    comb_illegal = 1'b0;
    case (ALUOperation)
      OP_ADD, OP_LW, OP_SW: comb_result = A + B;
      OP_SUB:               comb_result = A - B;
      OP_AND:               comb_result = A & B;
      OP_OR:                comb_result = A | B;
      OP_NOR:               comb_result = ~(A | B);
      OP_LUI:               comb_result = {B[15:0], {(N_BITS-16){1'b0}}};
      OP_BEQ: begin
        comb_result = A - B;
        comb_branch = (A == B);
      end
      OP_BNE: begin
        comb_result = A - B;
        comb_branch = (A != B);
      end
      OP_SLL, OP_SRL:       comb_result = B;
      default:              comb_illegal = 1'b1;
    endcase
  end

  assign is_shift    = (ALUOperation == OP_SLL) || (ALUOperation == OP_SRL);
  assign start_shift = Start && is_shift && (Shamt != '0);
  assign last_step   = (cnt == SHAMT_WIDTH'(1));
  assign shift_val   = dir_right ? (ALUResult >> 1) : (ALUResult << 1);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_shift) state_next = SHIFT;
      SHIFT:   if (last_step)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // ALUResult doubles as the shift register while an iterative shift runs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ALUResult   <= '0;
      Zero        <= 1'b1;
      BranchTaken <= 1'b0;
      IllegalOp   <= 1'b0;
      Done        <= 1'b0;
      cnt         <= '0;
      dir_right   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_shift) begin
            ALUResult <= B;
            cnt       <= Shamt;
            dir_right <= (ALUOperation == OP_SRL);
          end else if (Start) begin
            ALUResult   <= comb_result;
            Zero        <= (comb_result == '0);
            BranchTaken <= comb_branch;
            IllegalOp   <= comb_illegal;
            Done        <= 1'b1;
          end
        end
        SHIFT: begin
          ALUResult <= shift_val;
          cnt       <= cnt - SHAMT_WIDTH'(1);
          if (last_step) begin
            Zero        <= (shift_val == '0);
            BranchTaken <= 1'b0;
            IllegalOp   <= 1'b0;
            Done        <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequential.sv
// Bench for alu_sequential: driver pushes expected responses, a monitor pops them on Done.
module tb_alu_sequential;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  alu_op;
  logic [31:0] a, b;
  logic [4:0]  shamt;
  logic        busy, done, zero, branch_taken, illegal_op, fsm_state;
  logic [31:0] alu_result;

  // Packed expectation: {illegal, branch, zero, result}
  logic [34:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  alu_sequential #(.N_BITS(32), .SHAMT_WIDTH(5)) dut (
    .clk(clk), .reset(rst_n), .Start(start), .ALUOperation(alu_op),
    .A(a), .B(b), .Shamt(shamt), .Busy(busy), .Done(done),
    .ALUResult(alu_result), .Zero(zero), .BranchTaken(branch_taken),
    .IllegalOp(illegal_op), .fsm_state(fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [34:0] model(input logic [3:0] op, input logic [31:0] x,
                                        input logic [31:0] y, input logic [4:0] sh);
    logic [31:0] r;
    logic br, ill;
    r = 32'h0; br = 1'b0; ill = 1'b0;
    case (op)
      4'd0, 4'd11, 4'd12: r = x + y;
      4'd7:  r = x - y;
      4'd1:  r = x & y;
      4'd4:  r = x | y;
      4'd3:  r = ~(x | y);
      4'd10: r = y * 32'h0001_0000;
      4'd8:  begin r = x - y; br = (x == y); end
      4'd9:  begin r = x - y; br = (x != y); end
      4'd5:  r = y << sh;
      4'd6:  r = y >> sh;
      default: ill = 1'b1;
    endcase
    return {ill, br, (r == 32'h0), r};
  endfunction

  // Called at a falling edge; returns one falling edge after acceptance.
  task automatic send(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                      input logic [4:0] sh);
    int w = 0;
    while (busy && w < 64) begin
      @(negedge clk);
      w++;
    end
    if (w >= 64) begin
      checks++;
      $display("FAIL busy_wait_timeout: busy still 1 after 64 cycles, expected 0");
    end
    start = 1'b1; alu_op = op; a = x; b = y; shamt = sh;
    exp_q.push_back(model(op, x, y, sh));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Monitor: every Done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got done=1 with result 0x%08h, expected no done", alu_result);
      end else begin
        logic [34:0] e;
        e = exp_q.pop_front();
        check("result", alu_result, e[31:0]);
        check("zero", 32'(zero), 32'(e[32]));
        check("branch_taken", 32'(branch_taken), 32'(e[33]));
        check("illegal_op", 32'(illegal_op), 32'(e[34]));
      end
    end
  end

  task automatic drain(input int limit);
    int w = 0;
    while ((exp_q.size() != 0 || busy) && w < limit) begin
      @(negedge clk);
      w++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic shift_latency(input string name, input logic [3:0] op, input logic [31:0] y,
                               input logic [4:0] sh);
    int n = 0;
    send(op, 32'h0, y, sh);
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check(name, 32'(n), 32'(sh));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; alu_op = 4'h0; a = '0; b = '0; shamt = '0;
    repeat (3) @(negedge clk);
    check("rst_result", alu_result, 32'h0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_branch", 32'(branch_taken), 32'd0);
    check("rst_illegal", 32'(illegal_op), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed single-cycle ops
    send(4'd0, 32'hFFFF_FFFF, 32'h1, 5'd0);
    check("add_busy", 32'(busy), 32'd0);
    check("add_done", 32'(done), 32'd1);
    send(4'd8, 32'h1234, 32'h1234, 5'd0);
    send(4'd9, 32'h1234, 32'h1234, 5'd0);
    send(4'd9, 32'd5, 32'd3, 5'd0);
    send(4'd5, 32'h0, 32'hA5A5_A5A5, 5'd0);
    check("sll0_busy", 32'(busy), 32'd0);
    send(4'd10, 32'h0, 32'h0000_BEEF, 5'd0);
    send(4'd15, 32'hDEAD_BEEF, 32'h1, 5'd0);
    drain(10);

    // Iterative shifts: Busy duration equals the shift amount
    shift_latency("sll31_busy_cycles", 4'd5, 32'h1, 5'd31);
    shift_latency("srl4_busy_cycles", 4'd6, 32'h8000_0000, 5'd4);
    drain(10);

    // Start during a shift is ignored; Start on the Done cycle is accepted
    send(4'd6, 32'h0, 32'hF0F0_0000, 5'd10);
    repeat (3) @(negedge clk);
    start = 1'b1; alu_op = 4'd4; a = 32'h1111_0000; b = 32'h0000_2222; shamt = 5'd0;
    @(negedge clk);
    start = 1'b0;
    send(4'd4, 32'h1111_0000, 32'h0000_2222, 5'd0);
    check("done_cycle_accept", 32'(done), 32'd1);
    drain(20);

    // Reset in the middle of a 20-bit shift aborts it without a Done
    send(4'd5, 32'h0, 32'h0000_0003, 5'd20);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_result", alu_result, 32'h0);
    check("midrst_zero", 32'(zero), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);

    // Randomized traffic against the reference model
    for (int i = 0; i < 150; i++) begin
      logic [3:0]  op;
      logic [31:0] x, y;
      logic [4:0]  sh;
      op = 4'($urandom_range(0, 15));
      x  = $urandom();
      y  = ($urandom_range(0, 3) == 0) ? x : $urandom();
      sh = 5'($urandom_range(0, 31));
      send(op, x, y, sh);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    drain(100);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
